uart_work_rx: RTL and testbench
===============================

Name: uart_work_rx

Overview:
Frame assembler that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobe and byte, delimits frames by a sync byte, and collects a fixed-length work payload. It validates each frame with an 8-bit additive checksum and presents the completed work word to the hashing core over a valid/ready handshake. It also enforces an inter-byte timeout so that a truncated frame never wedges the link.

Parameters:
WORK_BYTES, 44, payload length in bytes (256-bit midstate + 96-bit data); legal range 1..255
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 16'd50000, maximum clk cycles allowed between consecutive bytes inside a frame; legal range 1..65535

Ports:
clk  in  1  single system clock (16x baud domain, same as the UART receiver)
rst_n  in  1  asynchronous active-low reset
rx_flag  in  1  one-cycle strobe from the UART receiver: rx_byte is valid
rx_byte  in  8  received byte
work_valid  out  1  work_data holds a checked frame
work_ready  in  1  consumer accepts work_data when high together with work_valid
work_data  out  8*WORK_BYTES  payload; first received payload byte occupies the MSBs [8*WORK_BYTES-1 -: 8]
err_checksum  out  1  one-cycle pulse: checksum mismatch, frame discarded
err_timeout  out  1  one-cycle pulse: inter-byte timeout, frame discarded
err_overrun  out  1  one-cycle pulse: good frame dropped because the previous work was not yet consumed

Behaviour:
- Reset (async assert, sync release): state=IDLE; work_valid=0; work_data=0; all err_* = 0; byte counter, checksum accumulator and timeout counter = 0.
- States: IDLE, PAYLOAD, CHECK.
- IDLE:
  - rx_flag with rx_byte==SYNC_BYTE -> PAYLOAD; clear byte count, sum and timer.
  - rx_flag with any other byte is ignored.
- PAYLOAD:
  - On each rx_flag: shift rx_byte into the assembly register from the LSB end (left shift by 8); sum <= sum + rx_byte (mod 256); count <= count + 1; timer cleared.
  - When the byte that brings count to WORK_BYTES is taken -> CHECK.
  - A SYNC_BYTE value received here is payload data and causes no resync.
- CHECK:
  - The next rx_flag is the checksum byte.
  - Good frame when (sum + rx_byte) mod 256 == 0, i.e. the checksum byte is the two's complement of the payload sum.
  - Good and (work_valid==0, or work_ready==1 this cycle): the next cycle has work_data = assembly register and work_valid=1. State -> IDLE.
  - Good but work_valid=1 and work_ready=0: frame dropped; err_overrun pulses 1 cycle; work_data unchanged. State -> IDLE.
  - Bad: err_checksum pulses 1 cycle; work outputs unchanged. State -> IDLE.
- Timeout:
  - In PAYLOAD and CHECK the timer increments every cycle without rx_flag.
  - When the timer reaches TIMEOUT_CYCLES: err_timeout pulses, state -> IDLE, assembly discarded.
  - rx_flag in the same cycle as expiry wins: the byte is processed and the timer clears.
- Handshake:
  - Transfer occurs on a cycle with work_valid & work_ready; work_valid falls the next cycle unless a new good frame loads in that same cycle, in which case it stays 1 with new data.
  - work_data is stable while work_valid=1 and not transferred.
  - work_valid never depends combinationally on work_ready.
- Latency: work_valid rises 1 cycle after the rx_flag carrying the checksum byte.
- The assembly register is separate from work_data, so reception of the next frame proceeds while work is pending.
- Error pulses are registered, mutually exclusive, and occur 1 cycle after the causing event.
- rst_n asserted mid-frame or with work pending: everything returns to reset values immediately; the partial frame and any pending work are lost.

Test Plan:
- WORK_BYTES=4: bytes A5,01,02,03,04,F6 -> work_data=32'h01020304, work_valid=1 one cycle after the F6 strobe; work_ready held 1 -> work_valid low next cycle.
- Same frame with checksum F7 -> err_checksum single pulse, work_valid stays 0, state back to IDLE; a following good frame is accepted.
- Frame 1 good with work_ready=0, then good frame 2 (A5,10,20,30,40,60) -> err_overrun pulse, work_data still 01020304; then ready=1 -> transfer, valid drops.
- TIMEOUT_CYCLES=100: A5,01,02 then silence -> err_timeout at exactly 100 cycles after the 02 strobe; a byte arriving on cycle 100 instead does not time out.
- Noise before sync (00,FF,5A) then a good frame -> only the good frame is delivered; payload containing A5 (A5,A5,00,00,00,5B) -> work_data=32'hA5000000.
- rst_n low for 1 cycle after 2 payload bytes, then a full good frame -> no errors, correct work_data delivered.

Source files
------------

// File: rtl/uart_work_rx.sv
// uart_work_rx: assembles sync-delimited, checksummed work frames from the
// UART byte stream and hands each good frame to the hashing core.
//
// Handshake: work_valid/work_data are registers. A transfer happens on any
// clock edge where work_valid & work_ready are both high. work_data is held
// stable while work_valid is high and no transfer has happened. work_valid
// never depends combinationally on work_ready.
module uart_work_rx #(
  parameter int unsigned WORK_BYTES     = 44,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_flag,
  input  logic [7:0]              rx_byte,
  output logic                    work_valid,
  input  logic                    work_ready,
  output logic [8*WORK_BYTES-1:0] work_data,
  output logic                    err_checksum,
  output logic                    err_timeout,
  output logic                    err_overrun,
  output logic [1:0]              dbg_state
);

  localparam int unsigned W        = 8 * WORK_BYTES;
  localparam logic [7:0]  LAST_IDX = 8'(WORK_BYTES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     sum_q, sum_d;
  logic [15:0]    timer_q, timer_d;
  logic [W-1:0]   asm_q, asm_d;
  logic [W-1:0]   work_q, work_d;
  logic           valid_q, valid_d;
  logic           err_ck_q, err_ck_d;
  logic           err_to_q, err_to_d;
  logic           err_ov_q, err_ov_d;

  logic           in_frame;
  logic           expire;
  logic [7:0]     chk;
  logic           frame_good;
  logic           frame_bad;
  logic           xfer;
  logic           load;

  // Timer hits its limit on a quiet cycle; a byte on that cycle wins.
  assign in_frame   = (state_q != S_IDLE);
  assign expire     = in_frame && !rx_flag && (timer_q == TMO_LAST);
  assign chk        = sum_q + rx_byte;
  assign frame_good = (state_q == S_CHECK) && rx_flag && (chk == 8'd0);
  assign frame_bad  = (state_q == S_CHECK) && rx_flag && (chk != 8'd0);
  assign xfer       = valid_q && work_ready;
  assign load       = frame_good && (!valid_q || work_ready);

  assign work_valid   = valid_q;
  assign work_data    = work_q;
  assign err_checksum = err_ck_q;
  assign err_timeout  = err_to_q;
  assign err_overrun  = err_ov_q;
  assign dbg_state    = state_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sum_q    <= '0;
      timer_q  <= '0;
      asm_q    <= '0;
      work_q   <= '0;
      valid_q  <= 1'b0;
      err_ck_q <= 1'b0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      timer_q  <= timer_d;
      asm_q    <= asm_d;
      work_q   <= work_d;
      valid_q  <= valid_d;
      err_ck_q <= err_ck_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end

  // Next frame-phase: sync opens a frame, the last payload byte moves to
  // the checksum phase, the checksum byte or a timeout closes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (rx_flag && rx_byte == SYNC_BYTE) state_d = S_PAYLOAD;
      S_PAYLOAD: begin
        if (expire)                               state_d = S_IDLE;
        else if (rx_flag && cnt_q == LAST_IDX)    state_d = S_CHECK;
      end
      S_CHECK:   if (expire || rx_flag)           state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Byte assembly, checksum, timer, work hand-off and error pulses.
  always_comb begin
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    timer_d  = timer_q;
    asm_d    = asm_q;
    work_d   = work_q;
    valid_d  = valid_q;
    err_to_d = 1'b0;
    err_ck_d = frame_bad;
    err_ov_d = frame_good && valid_q && !work_ready;

    if (state_q == S_IDLE) begin
      if (rx_flag && rx_byte == SYNC_BYTE) begin
        cnt_d   = '0;
        sum_d   = '0;
        timer_d = '0;
        asm_d   = '0;
      end
    end else if (rx_flag) begin
      timer_d = '0;
      if (state_q == S_PAYLOAD) begin
        asm_d = (asm_q << 8) | W'(rx_byte);
        sum_d = sum_q + rx_byte;
        cnt_d = cnt_q + 8'd1;
      end
    end else if (expire) begin
      timer_d  = '0;
      asm_d    = '0;
      err_to_d = 1'b1;
    end else begin
      timer_d = timer_q + 16'd1;
    end

    if (load) begin
      work_d  = asm_q;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_work_rx.sv
// Bench for uart_work_rx with a 4-byte payload and a 100-cycle timeout.
module tb_uart_work_rx;

  localparam int          WB   = 4;
  localparam int          TMO  = 100;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int          K_GOOD = 0;
  localparam int          K_CHK  = 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_flag = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        work_ready = 1'b0;
  logic        work_valid;
  logic [31:0] work_data;
  logic        err_checksum, err_timeout, err_overrun;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  uart_work_rx #(
    .WORK_BYTES     (WB),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_flag      (rx_flag),
    .rx_byte      (rx_byte),
    .work_valid   (work_valid),
    .work_ready   (work_ready),
    .work_data    (work_data),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .dbg_state    (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_mode = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_byte(logic [7:0] b);
    rx_flag = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_flag = 1'b0;
    if (rnd_mode) work_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_mode) work_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(logic [31:0] payload, logic [7:0] cks);
    drive_byte(SYNC);
    for (int i = 0; i < WB; i++) drive_byte(payload[31-8*i -: 8]);
    drive_byte(cks);
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Frame-level view: collect bytes in a queue, judge the frame when the
  // byte after the payload arrives, count quiet cycles for the timeout.
  bit          m_in_frame = 1'b0;
  logic [7:0]  m_payload[$];
  int          m_quiet = 0;
  bit          m_pending = 1'b0;
  logic [31:0] m_work = '0;
  bit          e_ck = 1'b0, e_to = 1'b0, e_ov = 1'b0;
  logic [31:0] exp_q[$];     // good frames expected to be delivered
  int          m_sum;
  logic [31:0] m_word;
  bit          m_xfer, m_loaded;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_frame = 1'b0;
      m_payload.delete();
      m_quiet    = 0;
      m_pending  = 1'b0;
      m_work     = '0;
      e_ck = 1'b0; e_to = 1'b0; e_ov = 1'b0;
      exp_q.delete();
    end else begin
      e_ck = 1'b0; e_to = 1'b0; e_ov = 1'b0;
      m_xfer   = m_pending && work_ready;
      m_loaded = 1'b0;
      if (m_xfer && exp_q.size() > 0) begin
        check("sb_delivered", m_work, exp_q.pop_front());
      end
      if (!m_in_frame) begin
        if (rx_flag && rx_byte == SYNC) begin
          m_in_frame = 1'b1;
          m_payload.delete();
          m_quiet = 0;
        end
      end else if (rx_flag) begin
        m_quiet = 0;
        if (m_payload.size() < WB) begin
          m_payload.push_back(rx_byte);
        end else begin
          m_sum  = int'(rx_byte);
          m_word = '0;
          foreach (m_payload[i]) begin
            m_sum  += int'(m_payload[i]);
            m_word  = (m_word << 8) | 32'(m_payload[i]);
          end
          if (m_sum % 256 == 0) begin
            if (!m_pending || work_ready) begin
              m_work   = m_word;
              m_loaded = 1'b1;
              exp_q.push_back(m_word);
            end else begin
              e_ov = 1'b1;
            end
          end else begin
            e_ck = 1'b1;
          end
          m_in_frame = 1'b0;
        end
      end else begin
        m_quiet++;
        if (m_quiet == TMO) begin
          e_to = 1'b1;
          m_in_frame = 1'b0;
        end
      end
      if (m_loaded)    m_pending = 1'b1;
      else if (m_xfer) m_pending = 1'b0;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("mdl_valid",  32'(work_valid),   32'(m_pending));
    check("mdl_data",   work_data,         m_work);
    check("mdl_err_ck", 32'(err_checksum), 32'(e_ck));
    check("mdl_err_to", 32'(err_timeout),  32'(e_to));
    check("mdl_err_ov", 32'(err_overrun),  32'(e_ov));
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [79:0] bytes;   // first byte in the MSBs
    int          n;
    int          kind;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[5];

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] pl;
    logic [7:0]  cks;
    int          r;

    vecs[0] = '{80'hA5_01_02_03_04_F6_00_00_00_00, 6, K_GOOD, 32'h01020304};
    vecs[1] = '{80'hA5_01_02_03_04_F7_00_00_00_00, 6, K_CHK,  32'h0};
    vecs[2] = '{80'h00_FF_5A_A5_01_02_03_04_F6_00, 9, K_GOOD, 32'h01020304};
    vecs[3] = '{80'hA5_A5_00_00_00_5B_00_00_00_00, 6, K_GOOD, 32'hA5000000};
    vecs[4] = '{80'hA5_10_20_30_40_60_00_00_00_00, 6, K_GOOD, 32'h10203040};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(work_valid), 32'h0);
    check("rst_data",  work_data,       32'h0);
    check("rst_errs",  32'({err_checksum, err_timeout, err_overrun}), 32'h0);
    check("rst_state", 32'(dbg_state),  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Table-driven frames with the consumer always ready
    work_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++) drive_byte(vecs[v].bytes[79-8*i -: 8]);
      @(negedge clk);
      if (vecs[v].kind == K_GOOD) begin
        check($sformatf("vec%0d_valid", v), 32'(work_valid), 32'h1);
        check($sformatf("vec%0d_data", v),  work_data,       vecs[v].data);
        check($sformatf("vec%0d_noerr", v),
              32'({err_checksum, err_timeout, err_overrun}), 32'h0);
        @(negedge clk);
        check($sformatf("vec%0d_valid_drop", v), 32'(work_valid), 32'h0);
      end else begin
        check($sformatf("vec%0d_err_ck", v), 32'(err_checksum), 32'h1);
        check($sformatf("vec%0d_novalid", v), 32'(work_valid),  32'h0);
        check($sformatf("vec%0d_idle", v),   32'(dbg_state),    32'h0);
        @(negedge clk);
        check($sformatf("vec%0d_err_ck_pulse", v), 32'(err_checksum), 32'h0);
      end
    end

    // Overrun: first frame pending, second good frame is dropped
    work_ready = 1'b0;
    send_frame(32'h01020304, 8'hF6);
    @(negedge clk);
    check("ovr_first_valid", 32'(work_valid), 32'h1);
    check("ovr_first_data",  work_data,       32'h01020304);
    send_frame(32'h10203040, 8'h60);
    @(negedge clk);
    check("ovr_pulse",      32'(err_overrun), 32'h1);
    check("ovr_data_kept",  work_data,        32'h01020304);
    check("ovr_still_valid", 32'(work_valid), 32'h1);
    @(negedge clk);
    check("ovr_pulse_end",  32'(err_overrun), 32'h0);
    work_ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", 32'(work_valid),  32'h0);

    // Timeout: silence after the 02 byte
    drive_byte(SYNC); drive_byte(8'h01); drive_byte(8'h02);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (err_timeout) check($sformatf("tmo_early_k%0d", k), 32'(err_timeout), 32'h0);
    end
    @(negedge clk);
    check("tmo_pulse", 32'(err_timeout), 32'h1);
    check("tmo_idle",  32'(dbg_state),   32'h0);
    @(negedge clk);
    check("tmo_pulse_end", 32'(err_timeout), 32'h0);

    // Byte arriving on the expiry cycle keeps the frame alive
    drive_byte(SYNC); drive_byte(8'h01); drive_byte(8'h02);
    repeat (TMO - 1) @(posedge clk);
    #1;
    drive_byte(8'h03); drive_byte(8'h04); drive_byte(8'hF6);
    @(negedge clk);
    check("late_valid", 32'(work_valid), 32'h1);
    check("late_data",  work_data,       32'h01020304);
    check("late_no_to", 32'(err_timeout), 32'h0);

    // Reset mid-frame and with work pending
    work_ready = 1'b0;
    send_frame(32'hDEADBEEF, 8'(8'h00 - (8'hDE + 8'hAD + 8'hBE + 8'hEF)));
    drive_byte(SYNC); drive_byte(8'h11); drive_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(work_valid), 32'h0);
    check("arst_data",  work_data,       32'h0);
    check("arst_state", 32'(dbg_state),  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    work_ready = 1'b1;
    send_frame(32'h0A0B0C0D, 8'(8'h00 - (8'h0A + 8'h0B + 8'h0C + 8'h0D)));
    @(negedge clk);
    check("post_rst_valid", 32'(work_valid), 32'h1);
    check("post_rst_data",  work_data,       32'h0A0B0C0D);
    check("post_rst_noerr", 32'({err_checksum, err_timeout, err_overrun}), 32'h0);

    // Randomized frames, gaps, noise, corruption, truncation, ready
    rnd_mode = 1'b1;
    for (int f = 0; f < 80; f++) begin
      r  = $urandom_range(0, 9);
      pl = $urandom;
      cks = 8'h00 - (pl[31:24] + pl[23:16] + pl[15:8] + pl[7:0]);
      if (r == 2) begin
        rx_byte = 8'($urandom_range(0, 255));
        drive_byte(rx_byte == SYNC ? 8'h00 : rx_byte);
      end
      if (r == 1) begin
        drive_byte(SYNC); drive_byte(pl[31:24]); drive_byte(pl[23:16]);
        idle(TMO + 3);
      end else begin
        if (r == 0) cks = cks ^ 8'($urandom_range(1, 255));
        drive_byte(SYNC);
        idle($urandom_range(0, 3));
        for (int i = 0; i < WB; i++) begin
          drive_byte(pl[31-8*i -: 8]);
          idle($urandom_range(0, 3));
        end
        drive_byte(cks);
        idle($urandom_range(0, 4));
      end
    end
    rnd_mode = 1'b0;
    work_ready = 1'b1;
    idle(5);
    check("final_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
